// File: rtl/usrt_tx_buffer.sv
// APB-programmable transmit buffer for a USRT: small byte FIFO feeding an
// 11-bit start/data/parity/stop frame to a downstream serializer.
module usrt_tx_buffer #(
    parameter int DEPTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        pSelect,
    input  logic        pEnable,
    input  logic        pWrite,
    input  logic [32:0] pAddress,
    input  logic [7:0]  pWData,
    output logic [7:0]  pRData,
    output logic        pReady,
    output logic [10:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        irq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    logic [7:0]    fifoMem [DEPTH];
    logic [PW-1:0] wrPtrReg;
    logic [PW-1:0] rdPtrReg;
    logic [CW-1:0] countReg;
    logic [1:0]    stateReg;
    logic [1:0]    stateNext;
    logic          overrunReg;
    logic          irqEnReg;
    logic          irqReg;
    logic [10:0]   frameReg;

    logic [1:0]    regSel;
    logic          apbWrite;
    logic          txWrite;
    logic          flush;
    logic          isFull;
    logic          isEmpty;
    logic          busy;
    logic          pop;
    logic          push;
    logic          dropped;
    logic [7:0]    headData;
    logic          parityBit;
    logic [7:0]    statusWord;
    logic          unusedAddrBits;

    assign unusedAddrBits = ^{pAddress[32:4], pAddress[1:0]};

    assign regSel   = pAddress[3:2];
    assign apbWrite = pSelect & pEnable & pWrite;
    assign txWrite  = apbWrite && (regSel == REG_TXDATA);
    assign flush    = apbWrite && (regSel == REG_CTRL) && pWData[1];

    assign isFull  = (countReg == CW'(DEPTH));
    assign isEmpty = (countReg == '0);
    assign busy    = (stateReg != IDLE);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign pop     = (stateReg == LOAD) && !isEmpty;
    assign push    = txWrite && (!isFull || pop) && !flush;
    assign dropped = txWrite && isFull && !pop;

    assign headData  = fifoMem[rdPtrReg];
    assign parityBit = PARITY_EN ? ^headData : 1'b1;

    assign statusWord = {overrunReg, busy, isFull, isEmpty, 4'(countReg)};

    assign pReady      = pSelect & pEnable;
    assign frame_valid = (stateReg == SEND);
    assign frame_data  = frameReg;
    assign irq         = irqReg;

    always_comb begin
        pRData = 8'h00;
        if (pSelect && !pWrite) begin
            case (regSel)
                REG_STATUS: pRData = statusWord;
                REG_CTRL:   pRData = {7'b0, irqEnReg};
                default:    pRData = 8'h00;
            endcase
        end
    end

    // IDLE also reacts to a write in flight so a fresh byte reaches SEND two cycles later.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (!isEmpty || push) stateNext = LOAD;
            LOAD:    stateNext = pop ? SEND : IDLE;
            SEND:    if (frame_ready) stateNext = isEmpty ? IDLE : LOAD;
            default: stateNext = IDLE;
        endcase
        if (flush) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge pClk) begin
        if (push) begin
            fifoMem[wrPtrReg] <= pWData;
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            stateReg   <= IDLE;
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            countReg   <= '0;
            overrunReg <= 1'b0;
            irqEnReg   <= 1'b0;
            irqReg     <= 1'b0;
            frameReg   <= 11'h7FF;
        end else begin
            stateReg <= stateNext;
            irqReg   <= irqEnReg & (overrunReg | (isEmpty & !busy));

            if (flush) begin
                wrPtrReg <= '0;
                rdPtrReg <= '0;
                countReg <= '0;
            end else begin
                if (push) begin
                    wrPtrReg <= wrPtrReg + 1'b1;
                end
                if (pop) begin
                    rdPtrReg <= rdPtrReg + 1'b1;
                    frameReg <= {1'b1, parityBit, headData, 1'b0};
                end
                if (push && !pop) begin
                    countReg <= countReg + 1'b1;
                end else if (pop && !push) begin
                    countReg <= countReg - 1'b1;
                end
            end

            if (dropped) begin
                overrunReg <= 1'b1;
            end else if (apbWrite && (regSel == REG_STATUS) && pWData[7]) begin
                overrunReg <= 1'b0;
            end

            if (apbWrite && (regSel == REG_CTRL)) begin
                irqEnReg <= pWData[0];
            end
        end
    end
endmodule

// File: tb/tb_usrt_tx_buffer.sv
// Scoreboard bench: expected frames are queued as bytes are written and a
// monitor pops them on each frame handshake; register reads are checked inline.
module tb_usrt_tx_buffer;
    logic        clk = 1'b0;
    logic        pReset;
    logic        pSelect;
    logic        pEnable;
    logic        pWrite;
    logic [32:0] pAddress;
    logic [7:0]  pWData;
    logic        frame_ready;

    logic [7:0]  pRData0, pRData1;
    logic        pReady0, pReady1;
    logic [10:0] frameData0, frameData1;
    logic        frameValid0, frameValid1;
    logic        irq0, irq1;

    int vectors = 0;
    int miscompares = 0;
    logic [10:0] expQ0[$];
    logic [10:0] expQ1[$];

    always #5 clk = ~clk;

    usrt_tx_buffer #(.DEPTH(4), .PARITY_EN(1'b1)) dut0 (
        .pClk(clk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
        .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData),
        .pRData(pRData0), .pReady(pReady0), .frame_data(frameData0),
        .frame_valid(frameValid0), .frame_ready(frame_ready), .irq(irq0)
    );

    usrt_tx_buffer #(.DEPTH(4), .PARITY_EN(1'b0)) dut1 (
        .pClk(clk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
        .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData),
        .pRData(pRData1), .pReady(pReady1), .frame_data(frameData1),
        .frame_valid(frameValid1), .frame_ready(frame_ready), .irq(irq1)
    );

    // data byte, expected frame with parity, expected frame with bit9 forced
    logic [7:0]  vecData [10] = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    logic [10:0] vecExp0 [10] = '{11'h54A, 11'h602, 11'h406, 11'h620, 11'h422, 11'h424, 11'h626, 11'h428, 11'h000, 11'h62C};
    logic [10:0] vecExp1 [10] = '{11'h74A, 11'h602, 11'h606, 11'h620, 11'h622, 11'h624, 11'h626, 11'h628, 11'h000, 11'h62C};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic expectFrame(input int idx);
        expQ0.push_back(vecExp0[idx]);
        expQ1.push_back(vecExp1[idx]);
    endtask

    task automatic apbWr(input logic [32:0] addr, input logic [7:0] data);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = addr; pWData = data;
        @(posedge clk); #1;
        pEnable = 1'b1;
        @(posedge clk); #1;
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    endtask

    task automatic apbRd(input logic [32:0] addr, input string name,
                         input logic [7:0] exp0, input logic [7:0] exp1);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = addr;
        @(posedge clk); #1;
        pEnable = 1'b1;
        #1;
        check({name, " pReady"}, 16'(pReady0), 16'h1);
        check({name, " dut0"}, 16'(pRData0), 16'(exp0));
        check({name, " dut1"}, 16'(pRData1), 16'(exp1));
        @(posedge clk); #1;
        pSelect = 1'b0; pEnable = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        pReset = 1'b1; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        pAddress = '0; pWData = '0; frame_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!pReset && frame_ready && frameValid0) begin
                    if (expQ0.size() == 0) check("frame0 unexpected", 16'(frameData0), 16'hFFFF);
                    else check("frame0", 16'(frameData0), 16'(expQ0.pop_front()));
                end
                if (!pReset && frame_ready && frameValid1) begin
                    if (expQ1.size() == 0) check("frame1 unexpected", 16'(frameData1), 16'hFFFF);
                    else check("frame1", 16'(frameData1), 16'(expQ1.pop_front()));
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 pReset = 1'b0;
        check("reset frame_valid", 16'(frameValid0), 16'h0);
        check("reset frame_data", 16'(frameData0), 16'h7FF);
        check("reset irq", 16'(irq0), 16'h0);
        apbRd(33'h4, "reset STATUS", 8'h10, 8'h10);
        apbRd(33'h8, "reset CTRL", 8'h00, 8'h00);

        // single byte, latency and bubble
        frame_ready = 1'b1;
        expectFrame(0);
        apbWr(33'h0, vecData[0]);
        check("A5 valid N+1", 16'(frameValid0), 16'h0);
        @(posedge clk); #1;
        check("A5 valid N+2", 16'(frameValid0), 16'h1);
        check("A5 frame_data", 16'(frameData0), 16'h54A);
        @(posedge clk); #1;
        check("A5 bubble", 16'(frameValid0), 16'h0);
        apbRd(33'h4, "A5 STATUS", 8'h10, 8'h10);

        for (int i = 1; i <= 2; i++) begin
            expectFrame(i);
            apbWr(33'h0, vecData[i]);
            repeat (4) @(posedge clk);
            #1;
        end

        // fill with serializer stalled: one in frame register, four queued, sixth dropped
        apbWr(33'h8, 8'h01);
        repeat (2) @(posedge clk);
        #1 check("irq idle empty", 16'(irq0), 16'h1);
        frame_ready = 1'b0;
        for (int i = 3; i <= 8; i++) begin
            if (i != 8) expectFrame(i);
            apbWr(33'h0, vecData[i]);
        end
        apbRd(33'h4, "full STATUS", 8'hE4, 8'hE4);
        check("full irq", 16'(irq0), 16'h1);
        check("stalled valid", 16'(frameValid0), 16'h1);
        check("stalled frame_data", 16'(frameData0), 16'h620);

        // clear overrun, then write coincident with the LOAD pop
        apbWr(33'h4, 8'h80);
        expectFrame(9);
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddress = 33'h0; pWData = vecData[9];
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0; pEnable = 1'b1;
        @(posedge clk); #1;
        pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        apbRd(33'h4, "push+pop STATUS", 8'h64, 8'h64);
        check("push+pop irq", 16'(irq0), 16'h0);

        frame_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        apbRd(33'h4, "drained STATUS", 8'h10, 8'h10);
        check("drained irq", 16'(irq0), 16'h1);
        check("queue0 empty", 16'(expQ0.size()), 16'h0);
        check("queue1 empty", 16'(expQ1.size()), 16'h0);

        // flush while sending; these frames are abandoned and never expected
        frame_ready = 1'b0;
        apbWr(33'h0, 8'h20);
        apbWr(33'h0, 8'h21);
        check("pre-flush valid", 16'(frameValid0), 16'h1);
        apbWr(33'h8, 8'h03);
        check("flush valid", 16'(frameValid0), 16'h0);
        apbRd(33'h4, "flush STATUS", 8'h10, 8'h10);
        apbRd(33'h8, "flush CTRL", 8'h01, 8'h01);

        // reset while sending
        apbWr(33'h0, 8'h22);
        @(posedge clk); #1;
        check("pre-reset valid", 16'(frameValid0), 16'h1);
        pReset = 1'b1;
        @(posedge clk); #1;
        pReset = 1'b0;
        check("reset-send valid", 16'(frameValid0), 16'h0);
        check("reset-send frame_data", 16'(frameData0), 16'h7FF);
        check("reset-send irq", 16'(irq0), 16'h0);
        apbRd(33'h4, "reset-send STATUS", 8'h10, 8'h10);
        apbRd(33'h8, "reset-send CTRL", 8'h00, 8'h00);
        check("final queue0", 16'(expQ0.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
